ts_os_rcvr: RTL

//  Per-lane TS1/TS2 ordered-set receiver, one instance per lane, upstream of the PHY LTSSM.
//  - Parses the MAC->PHY 8b symbol stream (txdata/txdatak) into 16-symbol training sets.
//  - Qualifies and classifies each set as TS1 or TS2, and exposes its link/lane/N_FTS/rate fields.
//  - Maintains the ts1/ts2 counters the LTSSM uses for its Polling and Config exit criteria.

---
 rtl/ozphy_pkg.sv | 15 +
 rtl/ts_os_rcvr.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/ozphy_pkg.sv
// Shared PHY constants and the ordered-set receiver state type.
package ozphy_pkg;

  localparam logic [7:0]  K_COM  = 8'hBC;
  localparam logic [7:0]  K_PAD  = 8'hF7;
  localparam logic [7:0]  TS1_ID = 8'h4A;
  localparam logic [7:0]  TS2_ID = 8'h45;
  localparam int unsigned TS_LEN = 16;

  typedef enum logic {
    OSR_IDLE,
    OSR_COLLECT
  } osr_state_e;

endpackage

// File: rtl/ts_os_rcvr.sv
// Per-lane TS1/TS2 ordered-set receiver: frames 16-symbol training sets, qualifies
// them, captures their fields and keeps the consecutive-match counters for the LTSSM.
module ts_os_rcvr
  import ozphy_pkg::*;
#(
  parameter int unsigned CNT_W  = 16,
  parameter logic [7:0]  ID_TS1 = TS1_ID,
  parameter logic [7:0]  ID_TS2 = TS2_ID
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_n,
  input  logic [7:0]       txdata,
  input  logic             txdatak,
  input  logic             clr_ts1,
  input  logic             clr_ts2,
  output logic             os_valid,
  output logic             os_is_ts2,
  output logic [7:0]       link_num,
  output logic [7:0]       lane_num,
  output logic [7:0]       n_fts,
  output logic [7:0]       rate_id,
  output logic [7:0]       train_ctl,
  output logic             link_proposed,
  output logic             lane_proposed,
  output logic [CNT_W-1:0] ts1_cnt,
  output logic [CNT_W-1:0] ts2_cnt,
  output logic             os_err
);

  localparam logic [3:0] LAST_IDX = 4'(TS_LEN - 1);

  osr_state_e       state, state_nxt;
  logic [3:0]       idx, idx_nxt;
  logic             bad, bad_nxt;
  logic             all1, all1_nxt, all2, all2_nxt;
  logic             fin_good, fin_err, store;
  logic             is_com, sym_bad;
  logic             good_ts1, good_ts2, match1, match2;
  logic [7:0]       sym_link, sym_lane, sym_nfts, sym_rate, sym_ctl;
  logic             ref1_ok, ref2_ok;
  logic [7:0]       ref1_link, ref1_lane, ref2_link, ref2_lane;
  logic [CNT_W-1:0] cnt1_nxt, cnt2_nxt;

  assign is_com = txdatak && (txdata == K_COM);

  always_comb begin
    sym_bad = 1'b0;
    if (idx == 4'd1 || idx == 4'd2)
      sym_bad = txdatak && (txdata != K_PAD);
    else if (idx >= 4'd3 && idx <= 4'd5)
      sym_bad = txdatak;
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    bad_nxt   = bad;
    all1_nxt  = all1;
    all2_nxt  = all2;
    fin_good  = 1'b0;
    fin_err   = 1'b0;
    store     = 1'b0;
    if (state == OSR_COLLECT && en_n) begin
      fin_err   = 1'b1;
      state_nxt = OSR_IDLE;
      idx_nxt   = '0;
    end else if (!en_n) begin
      if (is_com) begin
        // COM always (re)starts framing; inside a set it also aborts the old one
        fin_err   = (state == OSR_COLLECT);
        state_nxt = OSR_COLLECT;
        idx_nxt   = 4'd1;
        bad_nxt   = 1'b0;
        all1_nxt  = 1'b1;
        all2_nxt  = 1'b1;
      end else if (state == OSR_COLLECT) begin
        store   = 1'b1;
        bad_nxt = bad | sym_bad;
        if (idx >= 4'd6) begin
          all1_nxt = all1 & ~txdatak & (txdata == ID_TS1);
          all2_nxt = all2 & ~txdatak & (txdata == ID_TS2);
        end
        if (idx == LAST_IDX) begin
          state_nxt = OSR_IDLE;
          idx_nxt   = '0;
          fin_good  = !bad_nxt && (all1_nxt || all2_nxt);
          fin_err   = !fin_good;
        end else begin
          idx_nxt = idx + 4'd1;
        end
      end
    end
  end

  assign good_ts1 = fin_good & all1_nxt;
  assign good_ts2 = fin_good & ~all1_nxt;
  assign match1   = ref1_ok && (sym_link == ref1_link) && (sym_lane == ref1_lane);
  assign match2   = ref2_ok && (sym_link == ref2_link) && (sym_lane == ref2_lane);

  always_comb begin
    cnt1_nxt = ts1_cnt;
    cnt2_nxt = ts2_cnt;
    if (good_ts1)
      cnt1_nxt = !match1 ? CNT_W'(1) : ((&ts1_cnt) ? ts1_cnt : ts1_cnt + 1'b1);
    if (good_ts2)
      cnt2_nxt = !match2 ? CNT_W'(1) : ((&ts2_cnt) ? ts2_cnt : ts2_cnt + 1'b1);
    if (clr_ts1) cnt1_nxt = '0;
    if (clr_ts2) cnt2_nxt = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= OSR_IDLE;
      idx   <= '0;
      bad   <= 1'b0;
      all1  <= 1'b0;
      all2  <= 1'b0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      bad   <= bad_nxt;
      all1  <= all1_nxt;
      all2  <= all2_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sym_link      <= '0;
      sym_lane      <= '0;
      sym_nfts      <= '0;
      sym_rate      <= '0;
      sym_ctl       <= '0;
      os_valid      <= 1'b0;
      os_err        <= 1'b0;
      os_is_ts2     <= 1'b0;
      link_num      <= K_PAD;
      lane_num      <= K_PAD;
      n_fts         <= '0;
      rate_id       <= '0;
      train_ctl     <= '0;
      link_proposed <= 1'b0;
      lane_proposed <= 1'b0;
      ts1_cnt       <= '0;
      ts2_cnt       <= '0;
      ref1_ok       <= 1'b0;
      ref2_ok       <= 1'b0;
      ref1_link     <= '0;
      ref1_lane     <= '0;
      ref2_link     <= '0;
      ref2_lane     <= '0;
    end else begin
      if (store) begin
        case (idx)
          4'd1:    sym_link <= txdata;
          4'd2:    sym_lane <= txdata;
          4'd3:    sym_nfts <= txdata;
          4'd4:    sym_rate <= txdata;
          4'd5:    sym_ctl  <= txdata;
          default: ;
        endcase
      end
      os_valid <= fin_good;
      os_err   <= fin_err;
      ts1_cnt  <= cnt1_nxt;
      ts2_cnt  <= cnt2_nxt;
      if (fin_good) begin
        os_is_ts2 <= ~all1_nxt;
        link_num  <= sym_link;
        lane_num  <= sym_lane;
        n_fts     <= sym_nfts;
        rate_id   <= sym_rate;
        train_ctl <= sym_ctl;
      end
      if (good_ts1) begin
        link_proposed <= (sym_link != K_PAD);
        lane_proposed <= (sym_lane != K_PAD);
        ref1_ok       <= 1'b1;
        ref1_link     <= sym_link;
        ref1_lane     <= sym_lane;
      end
      if (good_ts2) begin
        ref2_ok   <= 1'b1;
        ref2_link <= sym_link;
        ref2_lane <= sym_lane;
      end
    end
  end

endmodule
